// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
// Provides the default bundle widths, the all-zero NOP control word, the
// control-bundle field layout and a helper that sizes occupancy counters.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CTRL_W = 24;
  localparam int DEF_DEPTH  = 1;
  localparam int DEF_SKID   = 1;

  // An all-zero control word is a bubble: no memory or register side effects.
  localparam logic [DEF_CTRL_W-1:0] NOP_CTRL = '0;

  // Control bundle layout, LSB first: mem_write is bit 0, bhw sits at [15:14].
  typedef struct packed {
    logic [7:0] rsvd;
    logic [1:0] bhw;
    logic [2:0] branch;
    logic [3:0] alu_control;
    logic       alu_b_src;
    logic       alu_a_src;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  // Counter width able to hold 0..depth+skid.
  function automatic int occ_width(input int depth, input int skid);
    return $clog2(depth + skid + 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline register slot: valid flag, control bundle and data bundle.
// Ports:
//   clk, rst            clock, async active-high reset
//   flush               clear valid and control (data holds)
//   load                capture load_ctrl/load_data and mark valid
//   drain               slot handed its beat onward without a refill
//   load_ctrl/load_data incoming bundle
//   valid/ctrl/data     registered slot contents
// Priority: rst > flush > load > drain. Control is zeroed whenever the slot
// goes empty so an invalid slot never carries a live control word.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
      ctrl  <= CTRL_W'(NOP_CTRL);
    end
  end

endmodule

// File: rtl/elastic_pipe_stage.sv
// Elastic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// DEPTH slots in series with a bubble-collapsing valid/ready chain, an
// optional one-entry input skid slot (SKID=1) that makes in_ready a flop,
// synchronous flush and an occupancy counter.
// Ports:
//   clk, rst                       clock, async active-high reset
//   in_valid/in_ready              upstream handshake
//   in_ctrl/in_data                upstream bundles
//   flush                          kill every held beat at the next edge
//   out_valid/out_ready            downstream handshake (out_ready low = stall)
//   out_ctrl/out_data              last-slot bundles, ctrl forced to NOP when empty
//   occupancy                      beats held across slots and skid
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SKID   = DEF_SKID
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CTRL_W-1:0]                 in_ctrl,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [CTRL_W-1:0]                 out_ctrl,
  output logic [DATA_W-1:0]                 out_data,
  output logic [occ_width(DEPTH, SKID)-1:0] occupancy
);

  localparam int CNT_W = occ_width(DEPTH, SKID);

  logic              slot_valid [DEPTH];
  logic [CTRL_W-1:0] slot_ctrl  [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];
  logic [DEPTH-1:0]  slot_adv;
  logic              head_ready;

  // Beat offered to slot 0 (either the skid entry or the input port).
  logic              src_valid;
  logic [CTRL_W-1:0] src_ctrl;
  logic [DATA_W-1:0] src_data;

  logic in_fire;
  logic out_fire;

  // Ready ripples from the output back to slot 0. A slot can advance when
  // the slot after it is empty or itself advancing; an empty slot is always
  // ready, which lets bubbles absorb a stall instead of propagating it.
  always_comb begin : ready_chain
    logic chain;
    chain    = out_ready;
    slot_adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      slot_adv[i] = slot_valid[i] & chain;
      chain       = chain | ~slot_valid[i];
    end
    head_ready = chain;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic              load;
    logic [CTRL_W-1:0] load_ctrl;
    logic [DATA_W-1:0] load_data;

    if (i == 0) begin : g_head
      assign load      = src_valid & head_ready;
      assign load_ctrl = src_ctrl;
      assign load_data = src_data;
    end else begin : g_body
      assign load      = slot_adv[i-1];
      assign load_ctrl = slot_ctrl[i-1];
      assign load_data = slot_data[i-1];
    end

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (load),
      .drain     (slot_adv[i]),
      .load_ctrl (load_ctrl),
      .load_data (load_data),
      .valid     (slot_valid[i]),
      .ctrl      (slot_ctrl[i]),
      .data      (slot_data[i])
    );
  end

  if (SKID != 0) begin : g_skid
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_drain;

    // While the skid holds a beat in_ready is low, so the skid always feeds
    // slot 0 ahead of any newer beat and order is preserved.
    assign skid_load  = in_valid & ~skid_valid & ~head_ready;
    assign skid_drain = skid_valid & head_ready;

    pipe_slot #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (skid_load),
      .drain     (skid_drain),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid),
      .ctrl      (skid_ctrl),
      .data      (skid_data)
    );

    assign in_ready  = ~skid_valid;
    assign src_valid = skid_valid | in_valid;
    assign src_ctrl  = skid_valid ? skid_ctrl : in_ctrl;
    assign src_data  = skid_valid ? skid_data : in_data;
  end else begin : g_no_skid
    assign in_ready  = head_ready;
    assign src_valid = in_valid;
    assign src_ctrl  = in_ctrl;
    assign src_data  = in_data;
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign out_valid = slot_valid[DEPTH-1];
  assign out_ctrl  = out_valid ? slot_ctrl[DEPTH-1] : CTRL_W'(NOP_CTRL);
  assign out_data  = slot_data[DEPTH-1];

endmodule
